// File: rtl/counter_quad.sv
// Debounced quadrature decoder with live position, snapshot and error flag.
// Define COUNTER_QUAD_ERR_EN to enable the sticky illegal-transition flag.
module counter_quad #(
    parameter int FILTER_SIZE = 4,
    parameter int COUNT_WIDTH = 8,
    parameter bit QUAD_FULL   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             q,
    input  logic                   smp,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [COUNT_WIDTH-1:0] count_smp,
    output logic                   err,
    input  logic                   err_clr
);

    localparam int PW = COUNT_WIDTH + 2;
    localparam logic [3:0] FLAST = 4'(FILTER_SIZE - 1);

    logic [1:0]             s1_q, s2_q;
    logic [1:0]             filt_q, filt_d;
    logic [1:0]             prev_q;
    logic [1:0][3:0]        run_q, run_d;
    logic [PW-1:0]          pos_q, pos_d;
    logic [COUNT_WIDTH-1:0] smp_q;
    logic [1:0]             diff;
    logic                   fwd, bwd, ill;

    // Gray code to phase index: 00->0, 01->1, 11->2, 10->3
    function automatic logic [1:0] gidx(input logic [1:0] v);
        return {v[1], v[1] ^ v[0]};
    endfunction

    always_comb begin
        filt_d = filt_q;
        run_d  = run_q;
        for (int b = 0; b < 2; b++) begin
            if (s2_q[b] == filt_q[b]) begin
                run_d[b] = '0;
            end else if (run_q[b] == FLAST) begin
                filt_d[b] = s2_q[b];
                run_d[b]  = '0;
            end else begin
                run_d[b] = run_q[b] + 4'd1;
            end
        end
    end

    assign diff = gidx(filt_q) - gidx(prev_q);
    assign fwd  = (diff == 2'd1);
    assign bwd  = (diff == 2'd3);
    assign ill  = (diff == 2'd2);

    always_comb begin
        pos_d = pos_q;
        unique case (1'b1)
            fwd:     pos_d = pos_q + PW'(1);
            bwd:     pos_d = pos_q - PW'(1);
            default: pos_d = pos_q;
        endcase
    end

    // Reset tracks raw q so release never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= q;
            s2_q   <= q;
            filt_q <= q;
            prev_q <= q;
            run_q  <= '0;
            pos_q  <= '0;
        end else begin
            s1_q   <= q;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            prev_q <= filt_q;
            run_q  <= run_d;
            pos_q  <= pos_d;
        end
    end

    assign count = QUAD_FULL ? pos_q[COUNT_WIDTH-1:0] : pos_q[PW-1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q <= '0;
        end else if (smp) begin
            smp_q <= count;
        end
    end

    assign count_smp = smp_q;

`ifdef COUNTER_QUAD_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end else if (ill) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_err;

    assign unused_err = err_clr ^ ill;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_counter_quad.sv
// Randomized and directed checks of counter_quad against a behavioural model.
module tb_counter_quad;

`ifdef COUNTER_QUAD_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, smp, err_clr;
    logic [1:0] q;
    logic [7:0] dc [3];
    logic [7:0] dcs[3];
    logic       de [3];

    always #5 clk = ~clk;

    counter_quad #(.FILTER_SIZE(4), .COUNT_WIDTH(8), .QUAD_FULL(1'b1)) u0 (
        .clk(clk), .rst(rst), .q(q), .smp(smp), .count(dc[0]),
        .count_smp(dcs[0]), .err(de[0]), .err_clr(err_clr));
    counter_quad #(.FILTER_SIZE(1), .COUNT_WIDTH(8), .QUAD_FULL(1'b1)) u1 (
        .clk(clk), .rst(rst), .q(q), .smp(smp), .count(dc[1]),
        .count_smp(dcs[1]), .err(de[1]), .err_clr(err_clr));
    counter_quad #(.FILTER_SIZE(4), .COUNT_WIDTH(8), .QUAD_FULL(1'b0)) u2 (
        .clk(clk), .rst(rst), .q(q), .smp(smp), .count(dc[2]),
        .count_smp(dcs[2]), .err(de[2]), .err_clr(err_clr));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         fsz[3] = '{4, 1, 4};
    bit         qf [3] = '{1'b1, 1'b1, 1'b0};
    int         mpos[3];
    logic [1:0] mf [3];
    logic [1:0] mfd[3];
    int         rlen[3][2];
    logic       rval[3][2];
    logic [7:0] msmp[3];
    logic       merr[3];
    logic [1:0] sd1, sd2;
    bit         mvalid = 1'b0;

    function automatic int gpos(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [7:0] mcount(input int i);
        if (qf[i]) return 8'(mpos[i] % 256);
        return 8'(mpos[i] / 4);
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mpos[i] = 0; mf[i] = q; mfd[i] = q;
                msmp[i] = '0; merr[i] = 1'b0;
                for (int b = 0; b < 2; b++) begin
                    rlen[i][b] = 0; rval[i][b] = q[b];
                end
            end
            sd1 = q; sd2 = q;
            mvalid = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                int d;
                d = (gpos(mf[i]) - gpos(mfd[i]) + 4) % 4;
                if (smp) msmp[i] = mcount(i);
                if (d == 1) mpos[i] = (mpos[i] + 1) % 1024;
                if (d == 3) mpos[i] = (mpos[i] + 1023) % 1024;
                if (ERR_ON) begin
                    if (err_clr) merr[i] = 1'b0;
                    else if (d == 2) merr[i] = 1'b1;
                end
                mfd[i] = mf[i];
                for (int b = 0; b < 2; b++) begin
                    if (sd2[b] == rval[i][b]) rlen[i][b]++;
                    else begin rval[i][b] = sd2[b]; rlen[i][b] = 1; end
                    if (rlen[i][b] >= fsz[i] && rval[i][b] != mf[i][b])
                        mf[i][b] = rval[i][b];
                end
            end
            sd2 = sd1; sd1 = q;
        end
    end

    initial forever begin
        @(negedge clk);
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("cyc_count%0d", i), 32'(dc[i]), 32'(mcount(i)));
                chk($sformatf("cyc_smp%0d", i), 32'(dcs[i]), 32'(msmp[i]));
                chk($sformatf("cyc_err%0d", i), 32'(de[i]), 32'(merr[i]));
            end
        end
    end

    // wrap monitor on the x4 FILTER_SIZE=4 instance
    bit         wmon = 1'b0;
    int         wraps = 0;
    logic [7:0] wprev = '0;

    initial forever begin
        @(negedge clk);
        if (wmon && wprev == 8'hFF && dc[0] == 8'h00) wraps++;
        wprev = dc[0];
    end

    // ---------------- stimulus ----------------
    logic [1:0] gray[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int gi;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fwd(input int hold);
        gi = (gi + 1) % 4; q = gray[gi]; tick(hold);
    endtask

    task automatic bwd(input int hold);
        gi = (gi + 3) % 4; q = gray[gi]; tick(hold);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(2); rst = 1'b0; tick(5);
    endtask

    initial begin
        int hold;
        rst = 1'b1; q = 2'b10; gi = 3; smp = 1'b0; err_clr = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(20);
        chk("rst_hold_count", 32'(dc[0]), 0);
        chk("rst_hold_count_x1", 32'(dc[2]), 0);
        chk("rst_hold_err", 32'(de[0]), 0);

        gi = 0; q = gray[0];
        tick(6);
        chk("latency_edge6", 32'(dc[0]), 0);
        tick(1);
        chk("latency_edge7", 32'(dc[0]), 1);
        tick(25);
        for (int k = 0; k < 11; k++) fwd(32);
        chk("fwd12_x4", 32'(dc[0]), 12);
        chk("fwd12_f1", 32'(dc[1]), 12);
        chk("fwd12_x1", 32'(dc[2]), 3);

        fwd(32); fwd(32);
        q = 2'b11; tick(3); q = 2'b01; tick(1);
        chk("glitch_f1_up", 32'(dc[1]), 15);
        tick(4);
        chk("glitch_f1_down", 32'(dc[1]), 14);
        tick(26);
        chk("glitch_f4_count", 32'(dc[0]), 14);
        chk("glitch_f4_err", 32'(de[0]), 0);

        gi = 3; q = 2'b10; tick(32);
        chk("illegal_count", 32'(dc[0]), 14);
        chk("illegal_err", 32'(de[0]), 32'(ERR_ON));
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        chk("err_clr", 32'(de[0]), 0);

        gi = 0; q = 2'b00; tick(6);
        smp = 1'b1; tick(1); smp = 1'b0;
        chk("smp_pre_update", 32'(dcs[0]), 14);
        chk("smp_count_after", 32'(dc[0]), 15);
        tick(25);

        do_reset();
        for (int k = 0; k < 10; k++) bwd(16);
        chk("bwd10_x1", 32'(dc[2]), 32'h0FD);
        chk("bwd10_x4", 32'(dc[0]), 246);

        do_reset();
        wmon = 1'b1;
        for (int k = 0; k < 256; k++) fwd(10);
        wmon = 1'b0;
        chk("wrap_once", 32'(wraps), 1);
        chk("wrap_count", 32'(dc[0]), 0);

        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                q = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 10);
            end
            hold--;
            smp     = ($urandom_range(0, 7) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 1'b0; smp = 1'b0; err_clr = 1'b0;
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
